rx_fir_mac_scheduler: RTL and testbench

- Sequencer and MAC for the time-multiplexed receive FIR filter.
- On each incoming sample:
  - writes the sample into a circular sample BRAM;
  - sweeps all NTAPS coefficient/sample address pairs;
  - accumulates the products and emits one saturated filtered sample with a valid strobe.
- Sits between the ADC sample stream and the downstream correlator. Sample and coefficient BRAMs are external, both with a 1-cycle read latency.

---
 rtl/rx_filter_pkg.sv | 27 ++
 rtl/rx_fir_mac_scheduler_if.sv | 41 ++++
 rtl/rx_mac_accum_sat.sv | 52 +++++
 rtl/rx_fir_mac_scheduler.sv | 126 ++++++++++++
 tb/tb_rx_fir_mac_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_filter_pkg.sv
// Shared constants and state encoding for the receive FIR MAC scheduler.
package rx_filter_pkg;

    localparam int NTAPS     = 128;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 40;
    localparam int OUT_SHIFT = 15;

    // Output clamp limits, at output width and at accumulator width.
    localparam int SAT_MAX_I = (2 ** (DATA_W - 1)) - 1;
    localparam int SAT_MIN_I = -(2 ** (DATA_W - 1));

    localparam logic signed [DATA_W-1:0] SAT_MAX     = DATA_W'(SAT_MAX_I);
    localparam logic signed [DATA_W-1:0] SAT_MIN     = DATA_W'(SAT_MIN_I);
    localparam logic signed [ACC_W-1:0]  SAT_MAX_ACC = ACC_W'(SAT_MAX_I);
    localparam logic signed [ACC_W-1:0]  SAT_MIN_ACC = ACC_W'(SAT_MIN_I);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/rx_fir_mac_scheduler_if.sv
// Sample stream, BRAM ports and result stream of the FIR MAC scheduler.
//
// Handshake: there is no ready. isample_valid is a one-cycle strobe; a
// sample offered while the scheduler is busy is discarded and reported by a
// one-cycle osample_drop pulse. ofiltered_valid is a one-cycle strobe and
// ofiltered_sample holds its value until the next strobe. Both BRAMs return
// read data one cycle after the address is presented.
interface rx_fir_mac_scheduler_if;
    import rx_filter_pkg::*;

    logic                     isample_valid;
    logic signed [DATA_W-1:0] isample;
    logic                     osample_we;
    logic [ADDR_W-1:0]        osample_wr_addr;
    logic signed [DATA_W-1:0] osample_wr_data;
    logic [ADDR_W-1:0]        osample_rd_addr;
    logic [ADDR_W-1:0]        ocoeff_rd_addr;
    logic signed [DATA_W-1:0] isample_rd;
    logic signed [DATA_W-1:0] icoeff_rd;
    logic signed [DATA_W-1:0] ofiltered_sample;
    logic                     ofiltered_valid;
    logic                     obusy;
    logic                     osample_drop;

    // Scheduler side.
    modport slave (
        input  isample_valid, isample, isample_rd, icoeff_rd,
        output osample_we, osample_wr_addr, osample_wr_data,
               osample_rd_addr, ocoeff_rd_addr,
               ofiltered_sample, ofiltered_valid, obusy, osample_drop
    );

    // Sample source / BRAM / consumer side.
    modport master (
        output isample_valid, isample, isample_rd, icoeff_rd,
        input  osample_we, osample_wr_addr, osample_wr_data,
               osample_rd_addr, ocoeff_rd_addr,
               ofiltered_sample, ofiltered_valid, obusy, osample_drop
    );

endinterface

// File: rtl/rx_mac_accum_sat.sv
// Signed multiply-accumulate with clear, followed by shift and saturation.
// sat_next reflects the accumulator value being loaded at the coming edge,
// so the caller can capture the final result in the same cycle as the last
// product is added.
module rx_mac_accum_sat
    import rx_filter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] coeff,
    output logic signed [DATA_W-1:0] sat_next
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    shifted;

    // Next accumulator value, then scale and clamp it to the output range.
    always_comb begin
        prod     = sample * coeff;
        prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + prod_ext;
        end
        shifted = acc_d >>> OUT_SHIFT;
        if (shifted > SAT_MAX_ACC) begin
            sat_next = SAT_MAX;
        end else if (shifted < SAT_MIN_ACC) begin
            sat_next = SAT_MIN;
        end else begin
            sat_next = shifted[DATA_W-1:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/rx_fir_mac_scheduler.sv
// Time-multiplexed receive FIR: stores each accepted sample in a circular
// BRAM, sweeps all taps, and emits one saturated filtered sample.
module rx_fir_mac_scheduler
    import rx_filter_pkg::*;
(
    input  logic                  crx_clk,
    input  logic                  rrx_rst,
    input  logic                  erx_en,
    rx_fir_mac_scheduler_if.slave bus,
    output state_e                odbg_state
);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]        tap_q, tap_d;
    logic signed [DATA_W-1:0] sample_q, sample_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     valid_q, valid_d;
    logic                     drop_q, drop_d;
    logic                     acc_clr;
    logic                     acc_en;
    logic signed [DATA_W-1:0] mac_sat;

    // Read data for tap k arrives while tap k+1 is addressed; the last one
    // arrives in DRAIN.
    assign acc_clr = (state_q == WRITE) || !erx_en;
    assign acc_en  = ((state_q == RUN) && (tap_q != '0)) || (state_q == DRAIN);

    rx_mac_accum_sat u_mac (
        .clk      (crx_clk),
        .rst_n    (rrx_rst),
        .clr      (acc_clr),
        .acc_en   (acc_en),
        .sample   (bus.isample_rd),
        .coeff    (bus.icoeff_rd),
        .sat_next (mac_sat)
    );

    // Next-state, pointer/tap sequencing and registered result/drop strobes.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        tap_d    = tap_q;
        sample_d = sample_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        drop_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.isample_valid) begin
                    sample_d = bus.isample;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                tap_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                tap_d = tap_q + 1'b1;
                if (tap_q == ADDR_W'(NTAPS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_d   = mac_sat;
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && bus.isample_valid) begin
            drop_d = 1'b1;
        end
        // Disable aborts any sweep in flight and wins over a coincident sample.
        if (!erx_en) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            tap_d    = '0;
            sample_d = '0;
            out_d    = '0;
            valid_d  = 1'b0;
            drop_d   = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge crx_clk) begin
        if (!rrx_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            tap_q    <= '0;
            sample_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            tap_q    <= tap_d;
            sample_q <= sample_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

    // BRAM ports are driven only in their own phase and read zero elsewhere.
    always_comb begin
        bus.osample_we       = (state_q == WRITE);
        bus.osample_wr_addr  = (state_q == WRITE) ? wr_ptr_q : '0;
        bus.osample_wr_data  = (state_q == WRITE) ? sample_q : '0;
        bus.osample_rd_addr  = (state_q == RUN) ? (wr_ptr_q - tap_q) : '0;
        bus.ocoeff_rd_addr   = (state_q == RUN) ? tap_q : '0;
        bus.ofiltered_sample = out_q;
        bus.ofiltered_valid  = valid_q;
        bus.obusy            = (state_q != IDLE);
        bus.osample_drop     = drop_q;
        odbg_state           = state_q;
    end

endmodule

// File: tb/tb_rx_fir_mac_scheduler.sv
// Bench for rx_fir_mac_scheduler: external BRAM models, a convolution-level
// reference model with a result queue, a per-cycle compare process and
// directed scenarios with hand-computed expectations.
module tb_rx_fir_mac_scheduler;
    import rx_filter_pkg::*;

    // ---------------- clock / reset ----------------
    logic   crx_clk = 1'b0;
    logic   rrx_rst = 1'b0;
    logic   erx_en  = 1'b0;
    state_e dbg_state;
    int     cyc     = 0;

    always #5 crx_clk = ~crx_clk;
    always @(posedge crx_clk) cyc <= cyc + 1;

    rx_fir_mac_scheduler_if bus ();

    rx_fir_mac_scheduler dut (
        .crx_clk    (crx_clk),
        .rrx_rst    (rrx_rst),
        .erx_en     (erx_en),
        .bus        (bus),
        .odbg_state (dbg_state)
    );

    // ---------------- external BRAMs (1-cycle read) ----------------
    logic signed [DATA_W-1:0] sample_mem [NTAPS];
    logic signed [DATA_W-1:0] coeff_mem  [NTAPS];

    always @(posedge crx_clk) begin
        if (bus.osample_we) sample_mem[bus.osample_wr_addr] <= bus.osample_wr_data;
        bus.isample_rd <= sample_mem[bus.osample_rd_addr];
        bus.icoeff_rd  <= coeff_mem[bus.ocoeff_rd_addr];
    end

    // ---------------- counters and checker ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline per accepted sample, counted from the cycle it is offered:
    // +1 write, +2..+NTAPS+1 tap sweep, +NTAPS+2 drain, +NTAPS+3 result.
    bit                       m_active = 1'b0;
    int                       m_age    = 0;
    int                       m_wr     = 0;
    logic signed [DATA_W-1:0] m_sample = '0;
    logic signed [DATA_W-1:0] m_out    = '0;
    bit                       m_drop   = 1'b0;
    logic signed [DATA_W-1:0] m_mem [NTAPS];
    logic signed [DATA_W-1:0] exp_q [$];

    function automatic logic signed [DATA_W-1:0] model_filter(input int wr);
        longint acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            acc += longint'(coeff_mem[k]) * longint'(m_mem[(wr - k + NTAPS) % NTAPS]);
        end
        acc = acc >>> OUT_SHIFT;
        if (acc > longint'(SAT_MAX_I)) acc = SAT_MAX_I;
        if (acc < longint'(SAT_MIN_I)) acc = SAT_MIN_I;
        return DATA_W'(acc);
    endfunction

    always @(posedge crx_clk) begin
        m_drop = 1'b0;
        if (!rrx_rst || !erx_en) begin
            m_active = 1'b0;
            m_age    = 0;
            m_wr     = 0;
            m_out    = '0;
        end else if (m_active) begin
            if (bus.isample_valid) m_drop = 1'b1;
            if (m_age == 1) m_mem[m_wr] = m_sample;
            if (m_age == NTAPS + 2) begin
                m_out = model_filter(m_wr);
                exp_q.push_back(m_out);
            end
            if (m_age == NTAPS + 3) begin
                m_active = 1'b0;
                m_age    = 0;
                m_wr     = (m_wr + 1) % NTAPS;
            end else begin
                m_age++;
            end
        end else if (bus.isample_valid) begin
            m_active = 1'b1;
            m_age    = 1;
            m_sample = bus.isample;
        end
    end

    // ---------------- per-cycle compare (negedge) ----------------
    bit                       cmp_en    = 1'b0;
    int                       valid_cnt = 0;
    int                       drop_cnt  = 0;
    int                       last_valid_cyc = -1;
    logic signed [DATA_W-1:0] obs_q [$];
    int                       wr_log [$];

    always @(negedge crx_clk) begin
        bit e_we, e_run, e_valid;
        int k;
        if (cmp_en) begin
            e_we    = m_active && (m_age == 1);
            e_run   = m_active && (m_age >= 2) && (m_age <= NTAPS + 1);
            e_valid = m_active && (m_age == NTAPS + 3);
            k       = m_age - 2;
            chk("busy", bus.obusy, m_active);
            chk("sample_we", bus.osample_we, e_we);
            if (e_we) begin
                chk("wr_addr", bus.osample_wr_addr, m_wr);
                chk("wr_data", bus.osample_wr_data, m_sample);
            end
            chk("coeff_rd_addr", bus.ocoeff_rd_addr, e_run ? k : 0);
            chk("sample_rd_addr", bus.osample_rd_addr, e_run ? (m_wr - k + NTAPS) % NTAPS : 0);
            chk("filtered_valid", bus.ofiltered_valid, e_valid);
            chk("filtered_sample", bus.ofiltered_sample, m_out);
            chk("sample_drop", bus.osample_drop, m_drop);
            if (bus.osample_we) wr_log.push_back(int'(bus.osample_wr_addr));
            if (bus.osample_drop) drop_cnt++;
            if (bus.ofiltered_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                obs_q.push_back(bus.ofiltered_sample);
                if (exp_q.size() > 0) chk("result_vs_queue", bus.ofiltered_sample, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic goto(input int tgt);
        while (cyc < tgt) begin
            @(posedge crx_clk);
            #1;
        end
    endtask

    task automatic drive_at(input int tgt, input int val);
        goto(tgt);
        bus.isample_valid = 1'b1;
        bus.isample       = DATA_W'(val);
        @(posedge crx_clk);
        #1;
        bus.isample_valid = 1'b0;
        bus.isample       = '0;
    endtask

    // Watchdog: the whole run is a bounded sequence of fixed-cycle waits.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int t0, t1, tc, ts, ta, tb, n0, vc;
        bus.isample_valid = 1'b0;
        bus.isample       = '0;
        for (int i = 0; i < NTAPS; i++) begin
            sample_mem[i] = '0;
            m_mem[i]      = '0;
            coeff_mem[i]  = '0;
        end

        // Reset state.
        repeat (3) @(posedge crx_clk);
        #1;
        cmp_en = 1'b1;
        @(negedge crx_clk);
        chk("reset_busy", bus.obusy, 0);
        chk("reset_valid", bus.ofiltered_valid, 0);
        chk("reset_out", bus.ofiltered_sample, 0);
        chk("reset_we", bus.osample_we, 0);
        chk("reset_state", dbg_state, IDLE);
        goto(cyc + 1);
        rrx_rst = 1'b1;
        erx_en  = 1'b1;

        // Impulse response, timing and write-pointer wrap.
        for (int k = 0; k < NTAPS; k++) coeff_mem[k] = DATA_W'(2 * (k + 1));
        t0 = cyc + 2;
        drive_at(t0, 16384);
        goto(t0 + 1);   @(negedge crx_clk);
        chk("t_we_at_T1", bus.osample_we, 1);
        chk("t_wr_addr0", bus.osample_wr_addr, 0);
        goto(t0 + 2);   @(negedge crx_clk);
        chk("t_we_off_T2", bus.osample_we, 0);
        chk("t_k0_saddr", bus.osample_rd_addr, 0);
        chk("t_k0_caddr", bus.ocoeff_rd_addr, 0);
        goto(t0 + 3);   @(negedge crx_clk);
        chk("t_k1_saddr", bus.osample_rd_addr, 127);
        chk("t_k1_caddr", bus.ocoeff_rd_addr, 1);
        goto(t0 + 129); @(negedge crx_clk);
        chk("t_k127_saddr", bus.osample_rd_addr, 1);
        chk("t_k127_caddr", bus.ocoeff_rd_addr, 127);
        goto(t0 + 130); @(negedge crx_clk);
        chk("t_no_valid_T130", bus.ofiltered_valid, 0);
        goto(t0 + 131); @(negedge crx_clk);
        chk("t_valid_T131", bus.ofiltered_valid, 1);
        goto(t0 + 132); @(negedge crx_clk);
        chk("t_valid_one_cycle", bus.ofiltered_valid, 0);
        chk("t_latency", last_valid_cyc - t0, 131);
        for (int i = 1; i < 130; i++) begin
            drive_at(t0 + 140 * i, 0);
            if (i == 128) begin
                goto(t0 + 140 * i + 3); @(negedge crx_clk);
                chk("wrap_k1_saddr", bus.osample_rd_addr, 127);
            end
        end
        goto(t0 + 140 * 129 + 135);
        chk("impulse_count", obs_q.size(), 130);
        for (int i = 0; i < obs_q.size() && i < 130; i++) begin
            chk("impulse_out", obs_q[i], (i < 128) ? i + 1 : 0);
        end
        chk("wrap_log_count", wr_log.size(), 130);
        if (wr_log.size() >= 130) begin
            chk("wrap_addr127", wr_log[127], 127);
            chk("wrap_addr128", wr_log[128], 0);
            chk("wrap_addr129", wr_log[129], 1);
        end

        // Overrun and minimum spacing, from a fresh reset.
        rrx_rst = 1'b0;
        goto(cyc + 3);
        rrx_rst = 1'b1;
        for (int k = 0; k < NTAPS; k++) coeff_mem[k] = 16'sd8192;
        drop_cnt = 0;
        n0 = obs_q.size();
        t1 = cyc + 2;
        drive_at(t1, 24000);
        drive_at(t1 + 10, -5000);
        goto(t1 + 135);
        chk("overrun_drop_once", drop_cnt, 1);
        tc = t1 + 140;
        drive_at(tc, 1000);
        goto(tc + 1);   @(negedge crx_clk);
        chk("overrun_next_addr", bus.osample_wr_addr, 1);
        drive_at(tc + 131, 333);
        drive_at(tc + 132, 0);
        goto(tc + 133); @(negedge crx_clk);
        chk("spacing_accept_addr", bus.osample_wr_addr, 2);
        goto(tc + 132 + 135);
        chk("spacing_drop_count", drop_cnt, 2);
        chk("overrun_out_count", obs_q.size() - n0, 3);
        if (obs_q.size() >= n0 + 3) begin
            chk("overrun_first", obs_q[n0], 6000);
            chk("overrun_second", obs_q[n0 + 1], 6250);
            chk("spacing_third", obs_q[n0 + 2], 6250);
        end

        // Saturation at both rails.
        for (int k = 0; k < NTAPS; k++) coeff_mem[k] = 16'sd32767;
        ts = cyc + 2;
        for (int i = 0; i < NTAPS; i++) drive_at(ts + 132 * i, 32767);
        goto(ts + 132 * 127 + 135);
        chk("sat_pos", obs_q[obs_q.size() - 1], 32767);
        ts = cyc + 2;
        for (int i = 0; i < NTAPS; i++) drive_at(ts + 132 * i, -32768);
        goto(ts + 132 * 127 + 135);
        chk("sat_neg", obs_q[obs_q.size() - 1], -32768);

        // Abort by erx_en at tap 50, with a coincident sample strobe.
        vc = valid_cnt;
        drop_cnt = 0;
        ta = cyc + 2;
        drive_at(ta, 1000);
        goto(ta + 52);
        erx_en = 1'b0;
        bus.isample_valid = 1'b1;
        bus.isample = 16'sd77;
        goto(ta + 53);
        erx_en = 1'b1;
        bus.isample_valid = 1'b0;
        bus.isample = '0;
        @(negedge crx_clk);
        chk("abort_en_busy", bus.obusy, 0);
        chk("abort_en_out", bus.ofiltered_sample, 0);
        goto(ta + 139);
        chk("abort_en_no_valid", valid_cnt - vc, 0);
        chk("abort_en_no_drop", drop_cnt, 0);
        drive_at(ta + 140, 1000);
        goto(ta + 141); @(negedge crx_clk);
        chk("abort_en_wrptr0", bus.osample_wr_addr, 0);

        // Abort by reset at tap 50.
        tb = ta + 140 + 140;
        drive_at(tb, 500);
        goto(tb - 1);
        chk("pre_rst_out_nonzero", bus.ofiltered_sample != 0, 1);
        vc = valid_cnt;
        goto(tb + 52);
        rrx_rst = 1'b0;
        goto(tb + 53);
        rrx_rst = 1'b1;
        @(negedge crx_clk);
        chk("abort_rst_busy", bus.obusy, 0);
        chk("abort_rst_out", bus.ofiltered_sample, 0);
        goto(tb + 139);
        chk("abort_rst_no_valid", valid_cnt - vc, 0);
        drive_at(tb + 140, 7);
        goto(tb + 141); @(negedge crx_clk);
        chk("abort_rst_wrptr0", bus.osample_wr_addr, 0);
        goto(tb + 140 + 135);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
